// File: rtl/ifb.sv
// Instruction fetch buffer: in-order IMEM reads paired with their PC in a
// DEPTH-slot queue, presented to the IDU; EXU jumps flush and drop stale data.
module ifb #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst_n,
  input  logic                  i_ifu_valid,
  output logic                  o_ifu_ready,
  input  logic [ADDR_WIDTH-1:0] i_ifu_pc,
  output logic                  o_mem_req_valid,
  input  logic                  i_mem_req_ready,
  output logic [ADDR_WIDTH-1:0] o_mem_req_addr,
  input  logic                  i_mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] i_mem_rsp_data,
  input  logic                  i_exu_jmp_en,
  output logic                  o_idu_valid,
  input  logic                  i_idu_ready,
  output logic [ADDR_WIDTH-1:0] o_idu_pc,
  output logic [DATA_WIDTH-1:0] o_idu_inst
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0] slot_pc   [DEPTH];
  logic [DATA_WIDTH-1:0] slot_inst [DEPTH];
  logic [DEPTH-1:0]      slot_dv;
  logic [PW-1:0]         wr_ptr, rsp_ptr, rd_ptr;
  logic [CW-1:0]         count, drop_cnt;

  logic [CW:0]   credit_sum;
  logic          credit_ok, flush, push, pop;
  logic          rsp_await, rsp_drop, rsp_fill, rsp_err;
  logic [CW-1:0] n_valid, inflight, flush_owed, drop_flush;

  assign flush      = i_exu_jmp_en;
  assign credit_sum = {1'b0, count} + {1'b0, drop_cnt};
  assign credit_ok  = credit_sum < (CW+1)'(DEPTH);

  assign o_mem_req_valid = i_sys_rst_n && i_ifu_valid && credit_ok && !flush;
  assign o_ifu_ready     = i_sys_rst_n && i_mem_req_ready && credit_ok && !flush;
  assign o_mem_req_addr  = i_ifu_pc;
  assign push            = i_ifu_valid && o_ifu_ready;

  // Awaiting slots lie between rsp_ptr and wr_ptr; equal pointers are ambiguous only when full.
  assign rsp_await = (rsp_ptr != wr_ptr) || ((count == CW'(DEPTH)) && !slot_dv[rsp_ptr]);
  assign rsp_drop  = i_mem_rsp_valid && (drop_cnt != '0);
  assign rsp_fill  = i_mem_rsp_valid && (drop_cnt == '0) && rsp_await && !flush;

  assign o_idu_valid = (count != '0) && slot_dv[rd_ptr] && !flush;
  assign o_idu_pc    = slot_pc[rd_ptr];
  assign o_idu_inst  = slot_inst[rd_ptr];
  assign pop         = o_idu_valid && i_idu_ready;

  always_comb begin
    n_valid = '0;
    for (int i = 0; i < DEPTH; i++) n_valid = n_valid + CW'(slot_dv[i]);
  end

  assign inflight   = count - n_valid;
  assign flush_owed = drop_cnt + inflight;
  assign drop_flush = (i_mem_rsp_valid && (flush_owed != '0)) ? flush_owed - 1'b1 : flush_owed;
  assign rsp_err    = i_mem_rsp_valid &&
                      (flush ? (flush_owed == '0) : ((drop_cnt == '0) && !rsp_await));

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_pc[i]   <= '0;
        slot_inst[i] <= '0;
      end
      slot_dv  <= '0;
      wr_ptr   <= '0;
      rsp_ptr  <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else if (flush) begin
      slot_dv  <= '0;
      wr_ptr   <= '0;
      rsp_ptr  <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= drop_flush;
    end else begin
      if (push) begin
        slot_pc[wr_ptr] <= i_ifu_pc;
        slot_dv[wr_ptr] <= 1'b0;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (rsp_drop) drop_cnt <= drop_cnt - 1'b1;
      if (rsp_fill) begin
        slot_inst[rsp_ptr] <= i_mem_rsp_data;
        slot_dv[rsp_ptr]   <= 1'b1;
        rsp_ptr            <= rsp_ptr + 1'b1;
      end
      if (pop) begin
        slot_dv[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // An unexpected response is ignored by the logic above; flag it here.
  rsp_err_a: assert property (@(posedge i_sys_clk) disable iff (!i_sys_rst_n) !rsp_err);

endmodule

// File: tb/tb_ifb.sv
// Directed bench for ifb: single fetch, fill/backpressure, flushes, pointer
// wrap against a random-latency memory model, and mid-stream reset.
module tb_ifb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_valid, ifu_ready;
  logic [31:0] ifu_pc;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid, d_rsp_valid, am_rsp_valid;
  logic [31:0] mem_rsp_data, d_rsp_data, am_rsp_data;
  logic        jmp_en;
  logic        idu_valid, idu_ready;
  logic [31:0] idu_pc, idu_inst;
  logic        auto_mem;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  assign mem_rsp_valid = auto_mem ? am_rsp_valid : d_rsp_valid;
  assign mem_rsp_data  = auto_mem ? am_rsp_data  : d_rsp_data;

  ifb #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4)) dut (
    .i_sys_clk      (clk),
    .i_sys_rst_n    (rst_n),
    .i_ifu_valid    (ifu_valid),
    .o_ifu_ready    (ifu_ready),
    .i_ifu_pc       (ifu_pc),
    .o_mem_req_valid(mem_req_valid),
    .i_mem_req_ready(mem_req_ready),
    .o_mem_req_addr (mem_req_addr),
    .i_mem_rsp_valid(mem_rsp_valid),
    .i_mem_rsp_data (mem_rsp_data),
    .i_exu_jmp_en   (jmp_en),
    .o_idu_valid    (idu_valid),
    .i_idu_ready    (idu_ready),
    .o_idu_pc       (idu_pc),
    .o_idu_inst     (idu_inst)
  );

  function automatic logic [31:0] imem(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifu_valid     = 1'b0;
    ifu_pc        = '0;
    mem_req_ready = 1'b1;
    d_rsp_valid   = 1'b0;
    d_rsp_data    = '0;
    jmp_en        = 1'b0;
    idu_ready     = 1'b0;
  endtask

  // Memory model: records accepted requests at negedge, answers in order with k in 1..3.
  int          mcyc = 0;
  int          last_due = 0;
  int          due_q[$];
  logic [31:0] addr_q[$];

  initial begin
    am_rsp_valid = 1'b0;
    am_rsp_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      mcyc++;
      am_rsp_valid = 1'b0;
      if (!rst_n) begin
        due_q.delete();
        addr_q.delete();
      end else if (due_q.size() != 0 && due_q[0] == mcyc) begin
        am_rsp_valid = 1'b1;
        am_rsp_data  = imem(addr_q[0]);
        void'(due_q.pop_front());
        void'(addr_q.pop_front());
      end
      @(negedge clk);
      if (auto_mem && rst_n && mem_req_valid && mem_req_ready) begin
        int due;
        due = mcyc + int'($urandom_range(1, 3));
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        due_q.push_back(due);
        addr_q.push_back(mem_req_addr);
      end
    end
  end

  task automatic single_fetch(input string tag, input logic [31:0] pc, input logic [31:0] inst);
    ifu_valid = 1'b1; ifu_pc = pc; idu_ready = 1'b1;
    #1;
    chk({tag, "_req_valid"}, mem_req_valid, 1);
    chk({tag, "_req_addr"}, mem_req_addr, pc);
    chk({tag, "_ifu_ready"}, ifu_ready, 1);
    tick();
    ifu_valid = 1'b0; d_rsp_valid = 1'b1; d_rsp_data = inst;
    #1;
    chk({tag, "_c1_idu_valid"}, idu_valid, 0);
    tick();
    d_rsp_valid = 1'b0;
    #1;
    chk({tag, "_c2_idu_valid"}, idu_valid, 1);
    chk({tag, "_c2_pc"}, idu_pc, pc);
    chk({tag, "_c2_inst"}, idu_inst, inst);
    tick();
    #1;
    chk({tag, "_c3_idu_valid"}, idu_valid, 0);
    chk({tag, "_c3_count"}, dut.count, 0);
    idle_inputs();
  endtask

  initial begin
    logic [31:0] exp_q[$];
    int pushed, popped, budget;

    auto_mem = 1'b0;
    idle_inputs();
    rst_n = 1'b0;
    ifu_valid = 1'b1; ifu_pc = 32'h1234;
    #12;
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_ifu_ready", ifu_ready, 0);
    chk("rst_idu_valid", idu_valid, 0);
    chk("rst_idu_pc", idu_pc, 0);
    chk("rst_idu_inst", idu_inst, 0);
    idle_inputs();
    tick();
    rst_n = 1'b1;
    tick();

    single_fetch("s1", 32'h8000_0000, 32'h0000_0013);

    // Fill with the IDU stalled; responses follow one cycle after each push.
    for (int i = 0; i < 5; i++) begin
      ifu_valid   = 1'b1;
      ifu_pc      = 32'(4 * i);
      d_rsp_valid = (i >= 1);
      d_rsp_data  = imem(32'(4 * (i - 1)));
      #1;
      chk($sformatf("fill_ready_%0d", i), ifu_ready, (i < 4) ? 1 : 0);
      tick();
    end
    d_rsp_valid = 1'b0; idu_ready = 1'b1;
    #1;
    chk("fill_ready_before_pop", ifu_ready, 0);
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        chk("fill_pop0_valid", idu_valid, 1);
      end else begin
        chk($sformatf("fill_ready_after_pop_%0d", i), ifu_ready, 1);
        chk($sformatf("fill_pop%0d_valid", i), idu_valid, 1);
      end
      chk($sformatf("fill_pop%0d_pc", i), idu_pc, 32'(4 * i));
      chk($sformatf("fill_pop%0d_inst", i), idu_inst, imem(32'(4 * i)));
      tick();
      ifu_valid = 1'b0;
      #1;
    end
    chk("fill_empty", idu_valid, 0);
    idle_inputs();

    // Flush with two requests in flight.
    ifu_valid = 1'b1; ifu_pc = 32'h10;
    tick();
    ifu_pc = 32'h14;
    tick();
    ifu_valid = 1'b0; jmp_en = 1'b1;
    #1;
    chk("fl2_ready_in_flush", ifu_ready, 0);
    tick();
    jmp_en = 1'b0; ifu_valid = 1'b1; ifu_pc = 32'h100;
    #1;
    chk("fl2_drop_cnt", dut.drop_cnt, 2);
    chk("fl2_new_ready", ifu_ready, 1);
    tick();
    ifu_valid = 1'b0; d_rsp_valid = 1'b1; d_rsp_data = 32'hDEAD_0010;
    #1;
    chk("fl2_stale0_valid", idu_valid, 0);
    tick();
    d_rsp_data = 32'hDEAD_0014;
    #1;
    chk("fl2_stale1_valid", idu_valid, 0);
    chk("fl2_drop_cnt_1", dut.drop_cnt, 1);
    tick();
    d_rsp_data = imem(32'h100);
    #1;
    chk("fl2_drop_cnt_0", dut.drop_cnt, 0);
    chk("fl2_own_not_yet", idu_valid, 0);
    tick();
    d_rsp_valid = 1'b0; idu_ready = 1'b1;
    #1;
    chk("fl2_new_valid", idu_valid, 1);
    chk("fl2_new_pc", idu_pc, 32'h100);
    chk("fl2_new_inst", idu_inst, imem(32'h100));
    tick();
    #1;
    chk("fl2_after_valid", idu_valid, 0);
    idle_inputs();

    // Flush coinciding with a response: one slot buffered, one in flight.
    ifu_valid = 1'b1; ifu_pc = 32'h20;
    tick();
    ifu_pc = 32'h24; d_rsp_valid = 1'b1; d_rsp_data = imem(32'h20);
    tick();
    ifu_valid = 1'b0; jmp_en = 1'b1; d_rsp_data = imem(32'h24);
    #1;
    chk("flr_valid_in_flush", idu_valid, 0);
    tick();
    jmp_en = 1'b0; d_rsp_valid = 1'b0;
    #1;
    chk("flr_drop_cnt", dut.drop_cnt, 0);
    chk("flr_idu_valid", idu_valid, 0);
    chk("flr_count", dut.count, 0);
    idle_inputs();
    tick();

    // Pointer wrap: 12 fetches, random memory latency and IDU stalls.
    auto_mem = 1'b1;
    pushed = 0; popped = 0; budget = 0;
    while ((pushed < 12 || popped < 12) && budget < 400) begin
      ifu_valid = (pushed < 12);
      ifu_pc    = 32'h4000 + 32'(4 * pushed);
      idu_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (ifu_valid && ifu_ready) begin
        exp_q.push_back(ifu_pc);
        pushed++;
      end
      if (idu_valid && idu_ready) begin
        if (exp_q.size() == 0) begin
          chk("wrap_extra_pop", idu_pc, 32'hFFFF_FFFF);
        end else begin
          chk($sformatf("wrap_pc_%0d", popped), idu_pc, exp_q[0]);
          chk($sformatf("wrap_inst_%0d", popped), idu_inst, imem(exp_q[0]));
          void'(exp_q.pop_front());
        end
        popped++;
      end
      tick();
      budget++;
    end
    chk("wrap_popped", popped, 12);
    idle_inputs();
    repeat (4) tick();
    #1;
    chk("wrap_no_dup", idu_valid, 0);
    chk("wrap_count", dut.count, 0);
    auto_mem = 1'b0;

    // Reset mid-stream with three slots holding data.
    for (int i = 0; i < 4; i++) begin
      ifu_valid   = (i < 3);
      ifu_pc      = 32'h200 + 32'(4 * i);
      d_rsp_valid = (i >= 1);
      d_rsp_data  = imem(32'h200 + 32'(4 * (i - 1)));
      tick();
    end
    d_rsp_valid = 1'b0;
    #1;
    chk("rstm_valid_before", idu_valid, 1);
    chk("rstm_count_before", dut.count, 3);
    ifu_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rstm_valid_in_reset", idu_valid, 0);
    chk("rstm_req_in_reset", mem_req_valid, 0);
    idle_inputs();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rstm_count_after", dut.count, 0);
    tick();
    single_fetch("s6", 32'h8000_0000, 32'h0000_0013);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
